// File: rtl/lshift_2_if.sv
// Bus bundle for the fixed left shifter: operand/qualifier in, combinational
// and registered results out.
interface lshift_2_if #(
    parameter int WIDTH = 32,
    parameter int SHAMT = 2
);
    logic [WIDTH-1:0] entrada;
    logic             in_valid;
    logic [WIDTH-1:0] saida;
    logic [WIDTH-1:0] saida_q;
    logic             out_valid;
    logic             overflow;
    logic [SHAMT-1:0] shifted_out;

    // Producer side: drives the operand and reads back results
    modport master (
        output entrada,
        output in_valid,
        input  saida,
        input  saida_q,
        input  out_valid,
        input  overflow,
        input  shifted_out
    );

    // Shifter side
    modport slave (
        input  entrada,
        input  in_valid,
        output saida,
        output saida_q,
        output out_valid,
        output overflow,
        output shifted_out
    );
endinterface

// File: rtl/lshift_2.sv
// Fixed-amount left shifter with a combinational result and a single
// registered stage that also reports the discarded high bits.
module lshift_2 #(
    parameter int WIDTH = 32,
    parameter int SHAMT = 2
) (
    input  logic       clk,
    input  logic       reset,
    lshift_2_if.slave  bus
);

    logic [SHAMT-1:0] discarded;

    // The shift itself: low bits zero-filled, top SHAMT bits dropped
    assign bus.saida = {bus.entrada[WIDTH-1-SHAMT:0], {SHAMT{1'b0}}};
    assign discarded = bus.entrada[WIDTH-1 -: SHAMT];

    // Single capture stage; results hold while idle, only the valid flag drops
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bus.saida_q     <= '0;
            bus.shifted_out <= '0;
            bus.overflow    <= 1'b0;
            bus.out_valid   <= 1'b0;
        end else if (bus.in_valid) begin
            bus.saida_q     <= bus.saida;
            bus.shifted_out <= discarded;
            bus.overflow    <= |discarded;
            bus.out_valid   <= 1'b1;
        end else begin
            bus.out_valid   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_lshift_2.sv
// Randomized, self-checking bench for lshift_2 with a behavioural model.
module tb_lshift_2;
    localparam int WIDTH = 32;
    localparam int SHAMT = 2;

    logic clk;
    logic reset;
    int   errors;
    int   checks;
    bit   check_en;

    lshift_2_if #(.WIDTH(WIDTH), .SHAMT(SHAMT)) bus ();

    lshift_2 #(.WIDTH(WIDTH), .SHAMT(SHAMT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model of the registered outputs
    logic [WIDTH-1:0] m_q;
    logic [SHAMT-1:0] m_sh;
    logic             m_ov;
    logic             m_v;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_q  = '0;
            m_sh = '0;
            m_ov = 1'b0;
            m_v  = 1'b0;
        end else if (bus.in_valid) begin
            m_q  = bus.entrada << SHAMT;
            m_sh = SHAMT'(bus.entrada >> (WIDTH - SHAMT));
            m_ov = (m_sh != 0);
            m_v  = 1'b1;
        end else begin
            m_v  = 1'b0;
        end
    end

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Per-cycle comparison of every output against the model
    always @(negedge clk) begin
        if (check_en) begin
            logic [WIDTH-1:0] exp_s;
            exp_s = bus.entrada << SHAMT;
            check("saida", 64'(bus.saida), 64'(exp_s));
            check("saida_q", 64'(bus.saida_q), 64'(m_q));
            check("shifted_out", 64'(bus.shifted_out), 64'(m_sh));
            check("overflow", 64'(bus.overflow), 64'(m_ov));
            check("out_valid", 64'(bus.out_valid), 64'(m_v));
        end
    end

    task automatic drive(input logic [WIDTH-1:0] e, input logic v);
        @(negedge clk);
        #1;
        bus.entrada  = e;
        bus.in_valid = v;
    endtask

    task automatic after_edge();
        @(posedge clk);
        #1;
    endtask

    initial begin
        errors   = 0;
        checks   = 0;
        check_en = 1'b0;
        reset    = 1'b0;
        bus.entrada  = '0;
        bus.in_valid = 1'b0;

        // Reset state
        #12;
        check("rst_saida_q", 64'(bus.saida_q), 64'h0);
        check("rst_out_valid", 64'(bus.out_valid), 64'h0);
        check("rst_overflow", 64'(bus.overflow), 64'h0);
        check("rst_shifted_out", 64'(bus.shifted_out), 64'h0);
        check_en = 1'b1;
        @(negedge clk);
        #1;
        reset = 1'b1;

        // Hand-computed vectors
        drive(32'h0000_0001, 1'b1);
        #1;
        check("v1_saida", 64'(bus.saida), 64'h4);
        after_edge();
        check("v1_saida_q", 64'(bus.saida_q), 64'h4);
        check("v1_overflow", 64'(bus.overflow), 64'h0);
        check("v1_shifted_out", 64'(bus.shifted_out), 64'h0);
        check("v1_out_valid", 64'(bus.out_valid), 64'h1);

        drive(32'hFFFF_FFFF, 1'b1);
        #1;
        check("v2_saida", 64'(bus.saida), 64'hFFFF_FFFC);
        after_edge();
        check("v2_overflow", 64'(bus.overflow), 64'h1);
        check("v2_shifted_out", 64'(bus.shifted_out), 64'h3);

        drive(32'h4000_0000, 1'b1);
        #1;
        check("v3_saida", 64'(bus.saida), 64'h0);
        after_edge();
        check("v3_saida_q", 64'(bus.saida_q), 64'h0);
        check("v3_overflow", 64'(bus.overflow), 64'h1);
        check("v3_shifted_out", 64'(bus.shifted_out), 64'h1);

        drive(32'h3FFF_FFFF, 1'b1);
        after_edge();
        check("v4_saida_q", 64'(bus.saida_q), 64'hFFFF_FFFC);
        check("v4_overflow", 64'(bus.overflow), 64'h0);

        // Idle cycles with a moving operand: results hold, valid drops
        for (int i = 0; i < 3; i++) begin
            drive(WIDTH'($urandom), 1'b0);
            after_edge();
            check("hold_saida_q", 64'(bus.saida_q), 64'hFFFF_FFFC);
            check("hold_out_valid", 64'(bus.out_valid), 64'h0);
            check("hold_overflow", 64'(bus.overflow), 64'h0);
        end

        // Asynchronous reset mid-stream
        drive(32'h1234_5678, 1'b1);
        @(posedge clk);
        #2;
        check("pre_rst_out_valid", 64'(bus.out_valid), 64'h1);
        reset = 1'b0;
        #1;
        check("mid_rst_saida_q", 64'(bus.saida_q), 64'h0);
        check("mid_rst_out_valid", 64'(bus.out_valid), 64'h0);
        check("mid_rst_saida", 64'(bus.saida), 64'h48D1_59E0);
        @(negedge clk);
        #1;
        reset = 1'b1;
        drive(32'h8000_0001, 1'b1);
        after_edge();
        check("post_rst_saida_q", 64'(bus.saida_q), 64'h4);
        check("post_rst_shifted_out", 64'(bus.shifted_out), 64'h2);
        check("post_rst_overflow", 64'(bus.overflow), 64'h1);
        check("post_rst_out_valid", 64'(bus.out_valid), 64'h1);

        // Random run, mostly back-to-back valid inputs
        for (int i = 0; i < 65536; i++) begin
            drive(WIDTH'($urandom), ($urandom_range(0, 3) != 0));
        end
        @(negedge clk);
        @(negedge clk);
        check_en = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
